midi_note_tracker: RTL
======================

// Module: midi_note_tracker
// PURPOSE
//  Upstream driver for the vibrato generator and channel pitch logic. Parses a MIDI byte stream
//  (from the UART receiver) for one selected channel and keeps a last-note-priority held-note stack.
//  Produces note_on / note_repeat / note_start / velocity for one monophonic Game Boy voice.
// PARAMETERS
//  STACK_DEPTH  4  held keys remembered for legato fall-back (2..8)
// PORTS
//  clk          in   1  core clock; the only clock
//  reset_n      in   1  synchronous, active-low reset
//  en           in   1  0: midi_valid ignored; parser and stack hold their state
//  midi_ch      in   4  channel to track; compared when a status byte is latched
//  midi_valid   in   1  1-cycle strobe: midi_data holds a new byte; back-to-back strobes allowed
//  midi_data    in   8  MIDI byte
//  note_on      out  1  1 while stack non-empty
//  note_repeat  out  1  1-cycle pulse: Note On for the key already on top while note_on=1
//  note_start   out  7  key on top of stack; holds last value when stack empties
//  velocity     out  7  velocity stored with top key
// BEHAVIOUR
//  Reset: note_on=0, note_repeat=0, note_start=0, velocity=0, stack empty, running status cleared.
//  Bytes are sampled on rising clk edge when reset_n && en && midi_valid.
//  Parser FSM: IDLE (no running status) -> D1 -> D2 -> D1 (running status) ... ; SYSEX.
//   - 0xF8-0xFF realtime: ignored; no change to state, running status or data1.
//   - 0x80-0xEF: latch status and match=(low nibble==midi_ch); go to D1.
//     Needed data bytes: 2 for 8x/9x/Ax/Bx/Ex; 1 for Cx/Dx.
//   - 0xF0: go to SYSEX and clear running status. Data bytes are dropped until the next status byte.
//     0xF1-0xF7: clear running status and go to IDLE.
//   - Data byte (bit7=0) in IDLE or SYSEX: dropped.
//     In D1: latch data1. For 1-byte messages the message completes here; return to D1.
//   - Data byte in D2 completes the message; return to D1 (running status).
//   - A status byte arriving in D2 abandons the partial message.
//  Completed messages act only if match=1:
//   - 9x vel>0: Note On. 9x vel=0 or 8x: Note Off.
//   - Bx data1=123: All Notes Off. Everything else is ignored.
//  Stack ops (entry = {key,vel}; index 0 = top):
//   - Note On, key not held: shift down and insert at top. If full, the bottom entry is discarded.
//   - Note On, key held: remove it, reinsert at top with new velocity.
//     If it was already the top and note_on=1, pulse note_repeat.
//   - Note Off: remove the matching entry and close the gap. Key not held: no effect.
//   - All Notes Off: empty the stack.
//  Timing:
//   - Stack and outputs update on the edge that samples the completing byte; visible next cycle.
//   - note_repeat is high exactly that one cycle.
//  Legato:
//   - Removing the top exposes the previous key. note_start changes, note_on stays 1, no note_repeat.
//   - Removing the last key drops note_on; note_start/velocity keep their values.
//  Stack never contains duplicate keys.
//  Reset mid-message: partial message discarded, stack emptied. midi_valid during reset is ignored.
//  midi_ch changes take effect at the next status byte; running status keeps its latched match.
// STRUCTURE
//  genmidi_pkg.vh (shared):
//   - status nibble localparams ST_NOTE_OFF=4'h8, ST_NOTE_ON=4'h9, ST_CC=4'hB
//   - CC_ALL_NOTES_OFF=7'd123
//   - parser state encodings PS_IDLE, PS_D1, PS_D2, PS_SYSEX
//  Sub-module note_stack: push/remove/clear ports, exposes top key/vel/empty/top_hit.
//  The parser stays in midi_note_tracker.
// TESTING
//  1 ch=0: 90 3C 64 -> note_on=1, note_start=60, velocity=100; then 80 3C 00 -> note_on=0, note_start=60.
//  2 Running status: 90 3C 64 40 50 -> top=64 vel=80; 3C 00 -> top stays 64;
//    40 00 -> note_on=0; note_repeat never pulses.
//  3 Repeat: 90 3C 64, then 3C 70 -> note_repeat exactly 1 cycle, velocity=112, note_start=60 throughout.
//  4 Overflow (depth 4): on 60,62,64,65,67 then off 67,65,64,62 -> note_start sequence 65,64,62,
//    then note_on=0 (60 discarded).
//  5 Filtering:
//   - 91 3C 64 with ch=0 -> no change.
//   - 90 3C F8 64 -> note on despite realtime byte.
//   - F0 3C 64 F7 -> no change.
//   - B0 7B 00 with notes held -> note_on=0.
//  6 Reset mid-message: 90 3C, reset_n=0 1 cycle, then 64 -> dropped (IDLE); all outputs 0.

Source files
------------

// File: rtl/midi_note_tracker_pkg.sv
// Shared constants and types for the MIDI note tracker: status nibbles,
// controller numbers, parser state encodings and the held-note stack entry.
package midi_note_tracker_pkg;

    localparam logic [3:0] ST_NOTE_OFF   = 4'h8;
    localparam logic [3:0] ST_NOTE_ON    = 4'h9;
    localparam logic [3:0] ST_CC         = 4'hB;
    localparam logic [3:0] ST_PROGRAM    = 4'hC;
    localparam logic [3:0] ST_CHAN_PRESS = 4'hD;

    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    localparam logic [1:0] PS_IDLE  = 2'd0;
    localparam logic [1:0] PS_D1    = 2'd1;
    localparam logic [1:0] PS_D2    = 2'd2;
    localparam logic [1:0] PS_SYSEX = 2'd3;

    typedef struct packed {
        logic [6:0] key;
        logic [6:0] vel;
    } stack_entry_t;

    // Program change and channel pressure carry a single data byte.
    function automatic logic is_one_byte_msg(input logic [3:0] status);
        return (status == ST_PROGRAM) || (status == ST_CHAN_PRESS);
    endfunction

endpackage

// File: rtl/midi_note_tracker_if.sv
// MIDI byte stream from the UART receiver: one-cycle valid strobe plus data byte.
interface midi_note_tracker_if;

    logic       midi_valid;
    logic [7:0] midi_data;

    modport master (output midi_valid, output midi_data);
    modport slave  (input  midi_valid, input  midi_data);

endinterface

// File: rtl/midi_note_tracker_note_stack.sv
// Last-note-priority held-key stack; index 0 is the top. Exposes the
// post-update top entry so the owner can register it on the same edge.
module midi_note_tracker_note_stack
    import midi_note_tracker_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       remove,
    input  logic       clear,
    input  logic [6:0] key,
    input  logic [6:0] vel,
    output logic       top_hit_c,
    output logic       empty_c,
    output logic [6:0] top_key_c,
    output logic [6:0] top_vel_c
);

    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    stack_entry_t             ent_q   [STACK_DEPTH];
    stack_entry_t             ent_d   [STACK_DEPTH];
    stack_entry_t             ent_ext [STACK_DEPTH+1];
    logic [STACK_DEPTH-1:0]   vld_q;
    logic [STACK_DEPTH-1:0]   vld_d;
    logic [STACK_DEPTH:0]     vld_ext;
    logic                     found;
    logic [IDX_W-1:0]         hit_idx;
    stack_entry_t             ins;

    // Locate the slot holding the addressed key (keys are unique).
    always_comb begin
        found   = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (vld_q[i] && (ent_q[i].key == key)) begin
                found   = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // One extra empty slot below the bottom makes the close-gap shift uniform.
    always_comb begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            ent_ext[i] = ent_q[i];
        end
        ent_ext[STACK_DEPTH] = '0;
        vld_ext              = {1'b0, vld_q};
    end

    always_comb begin
        ins   = '{key: key, vel: vel};
        ent_d = ent_q;
        vld_d = vld_q;
        if (clear) begin
            vld_d = '0;
        end else if (push) begin
            // Shift down up to the old copy of the key (or off the bottom if new).
            ent_d[0] = ins;
            vld_d[0] = 1'b1;
            for (int i = 1; i < STACK_DEPTH; i++) begin
                if (!found || (i <= int'(hit_idx))) begin
                    ent_d[i] = ent_q[i-1];
                    vld_d[i] = vld_q[i-1];
                end
            end
        end else if (remove && found) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (i >= int'(hit_idx)) begin
                    ent_d[i] = ent_ext[i+1];
                    vld_d[i] = vld_ext[i+1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign top_hit_c = vld_q[0] && (ent_q[0].key == key);
    assign empty_c   = !vld_d[0];
    assign top_key_c = ent_d[0].key;
    assign top_vel_c = ent_d[0].vel;

endmodule

// File: rtl/midi_note_tracker.sv
// MIDI channel-voice parser with running status feeding a held-note stack;
// drives note_on / note_repeat / note_start / velocity for one mono voice.
module midi_note_tracker
    import midi_note_tracker_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [3:0]            midi_ch,
    midi_note_tracker_if.slave    midi,
    output logic                  note_on,
    output logic                  note_repeat,
    output logic [6:0]            note_start,
    output logic [6:0]            velocity
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] status_q;
    logic [3:0] status_d;
    logic       match_q;
    logic       match_d;
    logic [6:0] data1_q;
    logic [6:0] data1_d;
    logic       msg_done_c;

    logic       byte_ok;
    logic [7:0] rx_byte;
    logic [6:0] data2;
    logic       act_c;
    logic       push_c;
    logic       remove_c;
    logic       clear_c;

    logic       top_hit_c;
    logic       empty_c;
    logic [6:0] top_key_c;
    logic [6:0] top_vel_c;

    assign byte_ok = en && midi.midi_valid;
    assign rx_byte = midi.midi_data;
    assign data2   = rx_byte[6:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= PS_IDLE;
            status_q <= '0;
            match_q  <= 1'b0;
            data1_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            match_q  <= match_d;
            data1_q  <= data1_d;
        end
    end

    // Parser next state; realtime bytes fall through leaving everything untouched.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        match_d    = match_q;
        data1_d    = data1_q;
        msg_done_c = 1'b0;
        if (byte_ok && (rx_byte[7:3] != 5'b11111)) begin
            if (rx_byte[7]) begin
                if (rx_byte[7:4] != 4'hF) begin
                    status_d = rx_byte[7:4];
                    match_d  = (rx_byte[3:0] == midi_ch);
                    state_d  = PS_D1;
                end else if (rx_byte == 8'hF0) begin
                    state_d = PS_SYSEX;
                end else begin
                    state_d = PS_IDLE;
                end
            end else begin
                case (state_q)
                    PS_D1: begin
                        data1_d = data2;
                        if (is_one_byte_msg(status_q)) begin
                            msg_done_c = 1'b1;
                        end else begin
                            state_d = PS_D2;
                        end
                    end
                    PS_D2: begin
                        msg_done_c = 1'b1;
                        state_d    = PS_D1;
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    // Decode completed channel messages into stack operations.
    assign act_c    = msg_done_c && match_q;
    assign push_c   = act_c && (status_q == ST_NOTE_ON) && (data2 != 7'd0);
    assign remove_c = act_c && ((status_q == ST_NOTE_OFF) ||
                                ((status_q == ST_NOTE_ON) && (data2 == 7'd0)));
    assign clear_c  = act_c && (status_q == ST_CC) && (data1_q == CC_ALL_NOTES_OFF);

    midi_note_tracker_note_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_c),
        .remove    (remove_c),
        .clear     (clear_c),
        .key       (data1_q),
        .vel       (data2),
        .top_hit_c (top_hit_c),
        .empty_c   (empty_c),
        .top_key_c (top_key_c),
        .top_vel_c (top_vel_c)
    );

    // Key and velocity hold their last values once the stack empties.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            note_on     <= 1'b0;
            note_repeat <= 1'b0;
            note_start  <= '0;
            velocity    <= '0;
        end else begin
            note_on     <= !empty_c;
            note_repeat <= push_c && top_hit_c;
            if (!empty_c) begin
                note_start <= top_key_c;
                velocity   <= top_vel_c;
            end
        end
    end

endmodule
